// File: rtl/ram_dp_clr_if.sv
// Bus bundle for ram_dp_clr: CPU read/write port A, renderer read-only port B
// and the ready/err status outputs.
interface ram_dp_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                    ready;
    logic                    err;

    logic                    a_en;
    logic                    a_we;
    logic [DATA_WIDTH/8-1:0] a_be;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_wdata;
    logic [DATA_WIDTH-1:0]   a_rdata;
    logic                    a_rvalid;

    logic                    b_en;
    logic [ADDR_WIDTH-1:0]   b_addr;
    logic [DATA_WIDTH-1:0]   b_rdata;
    logic                    b_rvalid;

    modport master (
        output a_en, a_we, a_be, a_addr, a_wdata, b_en, b_addr,
        input  ready, err, a_rdata, a_rvalid, b_rdata, b_rvalid
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_wdata, b_en, b_addr,
        output ready, err, a_rdata, a_rvalid, b_rdata, b_rvalid
    );
endinterface

// File: rtl/ram_dp_clr.sv
// Dual-port synchronous RAM: byte-lane read/write port A, read-only port B,
// self-clearing after every reset, write-through forwarding on A-write/B-read collisions.
module ram_dp_clr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic        clk,
    input  logic        reset,
    ram_dp_clr_if.slave bus
);
    localparam int                    NB        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] clr_cnt_r;
    logic                  ready_r;
    logic                  err_r;
    logic [DATA_WIDTH-1:0] a_rdata_r;
    logic                  a_rvalid_r;
    logic [DATA_WIDTH-1:0] b_rdata_r;
    logic                  b_rvalid_r;

    logic                  a_in_rng_s;
    logic                  b_in_rng_s;
    logic                  a_act_s;
    logic                  b_act_s;
    logic                  a_wr_s;
    logic [DATA_WIDTH-1:0] a_old_s;
    logic [DATA_WIDTH-1:0] b_old_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] b_word_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    // Decode port accesses and fetch the words they address (out-of-range reads yield zero).
    always_comb begin
        a_in_rng_s = ({1'b0, bus.a_addr} < DEPTH_W);
        b_in_rng_s = ({1'b0, bus.b_addr} < DEPTH_W);
        a_act_s    = (state_r == ST_READY) && bus.a_en;
        b_act_s    = (state_r == ST_READY) && bus.b_en;
        a_wr_s     = a_act_s && bus.a_we && a_in_rng_s;
        a_old_s    = '0;
        b_old_s    = '0;
        if (a_in_rng_s) begin
            a_old_s = mem_r[bus.a_addr];
        end else begin
            a_old_s = '0;
        end
        if (b_in_rng_s) begin
            b_old_s = mem_r[bus.b_addr];
        end else begin
            b_old_s = '0;
        end
        merged_s = merge_lanes(a_old_s, bus.a_wdata, bus.a_be);
        // B sees the merged word when A writes the same address this cycle
        if (a_wr_s && (bus.b_addr == bus.a_addr)) begin
            b_word_s = merged_s;
        end else begin
            b_word_s = b_old_s;
        end
    end

    // Single array write port shared by the clear sequencer and port A.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_r;
            mem_wdata_s = '0;
        end else if (a_wr_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = bus.a_addr;
            mem_wdata_s = merged_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; deliberately has no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Clear/ready sequencer plus registered read data, valid and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_CLEAR;
            clr_cnt_r  <= '0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            a_rdata_r  <= '0;
            a_rvalid_r <= 1'b0;
            b_rdata_r  <= '0;
            b_rvalid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r  <= clr_cnt_r + ADDR_WIDTH'(1);
                    a_rdata_r  <= '0;
                    a_rvalid_r <= 1'b0;
                    b_rdata_r  <= '0;
                    b_rvalid_r <= 1'b0;
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_READY: begin
                    a_rvalid_r <= a_act_s && !bus.a_we;
                    b_rvalid_r <= b_act_s;
                    if (a_act_s && !bus.a_we) begin
                        a_rdata_r <= a_old_s;
                    end
                    if (b_act_s) begin
                        b_rdata_r <= b_word_s;
                    end
                    if ((a_act_s && !a_in_rng_s) || (b_act_s && !b_in_rng_s)) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= '0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready    = ready_r;
    assign bus.err      = err_r;
    assign bus.a_rdata  = a_rdata_r;
    assign bus.a_rvalid = a_rvalid_r;
    assign bus.b_rdata  = b_rdata_r;
    assign bus.b_rvalid = b_rvalid_r;
endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised dual-port synchronous RAM; the next generation of the single-port data RAM in the ARM/pong design.
- Port A is read/write with byte-lane enables and serves the CPU data bus.
- Port B is read-only and serves the video/pong renderer.
- After every reset, a built-in clear sequencer zeroes the array and raises `ready`, so no external init file is needed.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6: word-address width.
- DEPTH, 64: number of implemented words; must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sequence has finished.
- a_en  in  1  port A access request.
- a_we  in  1  port A write (1) / read (0).
- a_be  in  DATA_WIDTH/8  port A byte-lane write enables; bit i covers data[8i+7:8i].
- a_addr  in  ADDR_WIDTH  port A word address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rdata  out  DATA_WIDTH  port A read data.
- a_rvalid  out  1  port A read data valid; one-cycle pulse.
- b_en  in  1  port B read request.
- b_addr  in  ADDR_WIDTH  port B word address.
- b_rdata  out  DATA_WIDTH  port B read data.
- b_rvalid  out  1  port B read data valid; one-cycle pulse.
- err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset: any edge with reset=1 sets state=CLEAR, clr_cnt=0, ready=0, a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, err=0. Array contents are not touched during reset itself.
- Reset mid-clear or mid-operation restarts the sequence from clr_cnt=0.
- FSM:
  - CLEAR: each edge with reset=0 writes mem[clr_cnt]=0 and increments clr_cnt.
  - On the edge that writes clr_cnt==DEPTH-1, go to READY and set ready=1.
  - ready is therefore first seen high after exactly DEPTH edges following reset deassertion.
  - READY: normal operation; stays there until the next reset.
- During CLEAR, a_en and b_en are ignored: no writes, rvalid=0, rdata=0, err unchanged.
- Port A write (READY, a_en=1, a_we=1, a_addr<DEPTH):
  - Each lane with a_be[i]=1 takes a_wdata's byte i; other lanes keep their value.
  - a_be=0 is a legal no-op.
  - a_rvalid=0 on writes.
- Port A read (a_en=1, a_we=0): a_rdata=mem[a_addr] at the next edge; a_rvalid=1 for that one cycle. Latency is 1.
- Port B read: same timing as port A read, with b_rdata/b_rvalid.
- Between reads, rdata holds its last value and rvalid=0.
- Collision, port A write and port B read to the same address in the same cycle: b_rdata returns the post-write merged word (write-through forwarding), including the unwritten lanes' old bytes.
- Back-to-back: one access per port per cycle; full throughput with no stalls.
- Out of range (addr ≥ DEPTH, READY, en=1) on either port:
  - The write is dropped and the array is unchanged.
  - A read returns 0 with rvalid=1.
  - err is set to 1 and stays set until reset.
- Simultaneous out-of-range on both ports behaves the same: err=1 and both reads return 0.
- Enables are sampled only on the edge; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset for 2 cycles, release, all ports idle → ready=0 for 63 edges, ready=1 on edge 64; port B reads of addrs 0..63 all return 0 with rvalid=1.
- Port A writes 0xDEADBEEF to addr 5 with a_be=4'b1111, then writes 0x00001100 with a_be=4'b0010 → port A read of addr 5 returns 0xDEAD11EF one cycle after the request.
- Same-cycle collision: A writes 0x12345678 to addr 9 (be=1111) while B reads addr 9 → b_rdata=0x12345678 on the next edge; an A read of addr 9 the following cycle returns the same value.
- DEPTH=48, ADDR_WIDTH=6: A writes addr 50, then B reads addr 50 → write dropped, b_rdata=0, b_rvalid=1, err=1 and stays 1 for 10 further idle cycles.
- Mid-operation reset after writing 0xAAAAAAAA to addr 3, with a_en pulsed during the clear window → ready=0 for 64 edges, the pulsed access gives a_rvalid=0, and a read of addr 3 after ready returns 0.
- Streaming: 64 consecutive A writes of the address value to addrs 0..63, then 64 consecutive B reads → b_rvalid high every cycle, and the data equals the address with 1-cycle latency.
